// File: rtl/sram_cache.sv
// Two-way set-associative write-through read cache in front of SRAM_Controller.
// Define SRAM_CACHE_WRITE_UPDATE_EN to update write-hit lines in place instead of invalidating them.
module sram_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready,
  output logic        hit
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t      state, state_next;
  logic [31:0] ca;
  logic        word_sel;
  logic [5:0]  index;
  logic [9:0]  tag;
  logic [63:0] valid0, valid1, lru;
  logic [9:0]  tag0  [64];
  logic [9:0]  tag1  [64];
  logic [63:0] data0 [64];
  logic [63:0] data1 [64];
  logic        match0, match1, victim;
  logic        fill, wdone, wr_update, wr_inval;
  logic [63:0] line;
  logic        unused_addr;

  assign ca          = address - 32'd1024;
  assign word_sel    = ca[2];
  assign index       = ca[8:3];
  assign tag         = ca[18:9];
  assign unused_addr = ^{ca[31:19], ca[1:0]};

  assign match0 = valid0[index] && (tag0[index] == tag);
  assign match1 = valid1[index] && (tag1[index] == tag);
  assign hit    = mem_r_en && !mem_w_en && (state == IDLE) && (match0 || match1);
  assign victim = !valid0[index] ? 1'b0 : (!valid1[index] ? 1'b1 : lru[index]);
  assign fill   = (state == READ) && sram_ready;
  assign wdone  = (state == WRITE) && sram_ready;

`ifdef SRAM_CACHE_WRITE_UPDATE_EN
  assign wr_update = wdone;
  assign wr_inval  = 1'b0;
`else
  assign wr_update = 1'b0;
  assign wr_inval  = wdone;
`endif

  assign ready = ((state == IDLE) && !mem_r_en && !mem_w_en) || hit ||
                 ((state != IDLE) && sram_ready);
  assign sram_r_en    = (state == READ);
  assign sram_w_en    = (state == WRITE);
  assign sram_address = address;
  assign sram_wdata   = wdata;
  assign line         = match0 ? data0[index] : data1[index];

  always_comb begin
    rdata = '0;
    if (hit)
      rdata = word_sel ? line[63:32] : line[31:0];
    else if (fill)
      rdata = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mem_w_en)
          state_next = WRITE;
        else if (mem_r_en && !(match0 || match1))
          state_next = READ;
      end
      READ, WRITE: begin
        if (sram_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      state <= state_next;
      // LRU names the way that was not just used
      if (hit)
        lru[index] <= match0;
      if (fill) begin
        if (victim) valid1[index] <= 1'b1;
        else        valid0[index] <= 1'b1;
        lru[index] <= ~victim;
      end
      if (wr_inval) begin
        if (match0) valid0[index] <= 1'b0;
        if (match1) valid1[index] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      if (victim) begin
        tag1[index]  <= tag;
        data1[index] <= sram_rdata;
      end else begin
        tag0[index]  <= tag;
        data0[index] <= sram_rdata;
      end
    end
    if (wr_update) begin
      if (match0) begin
        if (word_sel) data0[index][63:32] <= wdata;
        else          data0[index][31:0]  <= wdata;
      end
      if (match1) begin
        if (word_sel) data1[index][63:32] <= wdata;
        else          data1[index][31:0]  <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_cache.sv
// Directed self-checking bench for sram_cache; follows SRAM_CACHE_WRITE_UPDATE_EN like the design.
module tb_sram_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        ready, sram_r_en, sram_w_en, hit;
  logic [31:0] sram_address, sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  sram_cache dut (
    .clk          (clk),
    .rst          (rst),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_r_en    (sram_r_en),
    .sram_w_en    (sram_w_en),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready),
    .hit          (hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    settle();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic read_miss(input logic [31:0] a, input logic [63:0] ln,
                           input int unsigned lat, input logic [31:0] exp);
    mem_r_en = 1'b1; mem_w_en = 1'b0; address = a;
    settle();
    chk("miss_hit", hit, 1'b0);
    chk("miss_ready_req", ready, 1'b0);
    chk("miss_ren_req", sram_r_en, 1'b0);
    cyc();
    chk("miss_ren_c1", sram_r_en, 1'b1);
    chk("miss_ready_c1", ready, 1'b0);
    repeat (lat) begin
      cyc();
      chk("miss_ready_wait", ready, 1'b0);
    end
    sram_ready = 1'b1; sram_rdata = ln;
    settle();
    chk("miss_ready_done", ready, 1'b1);
    chk("miss_rdata", rdata, exp);
    chk("miss_ren_done", sram_r_en, 1'b1);
    cyc();
    sram_ready = 1'b0; sram_rdata = '0; mem_r_en = 1'b0;
    settle();
    chk("miss_ren_after", sram_r_en, 1'b0);
    chk("miss_ready_after", ready, 1'b1);
  endtask

  task automatic read_hit(input logic [31:0] a, input logic [31:0] exp);
    mem_r_en = 1'b1; mem_w_en = 1'b0; address = a;
    settle();
    chk("hit_hit", hit, 1'b1);
    chk("hit_ready", ready, 1'b1);
    chk("hit_rdata", rdata, exp);
    chk("hit_ren", sram_r_en, 1'b0);
    cyc();
    chk("hit_ren_next", sram_r_en, 1'b0);
    mem_r_en = 1'b0;
    settle();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic both, input int unsigned lat);
    mem_w_en = 1'b1; mem_r_en = both; address = a; wdata = d;
    settle();
    chk("wr_hit", hit, 1'b0);
    chk("wr_ready_req", ready, 1'b0);
    chk("wr_wen_req", sram_w_en, 1'b0);
    cyc();
    chk("wr_wen_c1", sram_w_en, 1'b1);
    chk("wr_ren_c1", sram_r_en, 1'b0);
    chk("wr_wdata", sram_wdata, d);
    chk("wr_address", sram_address, a);
    repeat (lat) begin
      cyc();
      chk("wr_ready_wait", ready, 1'b0);
      chk("wr_wen_wait", sram_w_en, 1'b1);
    end
    sram_ready = 1'b1;
    settle();
    chk("wr_ready_done", ready, 1'b1);
    cyc();
    sram_ready = 1'b0; mem_w_en = 1'b0; mem_r_en = 1'b0;
    settle();
    chk("wr_wen_after", sram_w_en, 1'b0);
    chk("wr_ready_after", ready, 1'b1);
  endtask

  initial begin
    rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    address = 32'h400; wdata = '0; sram_rdata = '0; sram_ready = 1'b0;
    #1;
    chk("rst_hit", hit, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ren", sram_r_en, 1'b0);
    chk("rst_wen", sram_w_en, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();

    // Cold miss then hit on the other word
    read_miss(32'h400, 64'h22222222_11111111, 6, 32'h11111111);
    read_hit(32'h404, 32'h22222222);

    // Same set: 0x400 way0, 0x600 way1, 0xA00 evicts the LRU way1
    read_miss(32'h600, 64'h44444444_33333333, 2, 32'h33333333);
    read_hit(32'h400, 32'h11111111);
    read_miss(32'hA00, 64'h66666666_55555555, 1, 32'h55555555);
    read_hit(32'h400, 32'h11111111);
    read_miss(32'h600, 64'h44444444_33333333, 1, 32'h33333333);

    // Write hit on 0x400
    do_write(32'h400, 32'hDEADBEEF, 1'b0, 3);
`ifdef SRAM_CACHE_WRITE_UPDATE_EN
    read_hit(32'h400, 32'hDEADBEEF);
    read_hit(32'h404, 32'h22222222);
`else
    read_miss(32'h400, 64'hAAAAAAAA_BBBBBBBB, 2, 32'hBBBBBBBB);
    read_hit(32'h404, 32'hAAAAAAAA);
`endif
    read_hit(32'h600, 32'h33333333);

    // Both enables high is a write; cached 0x600 must not report a hit
    do_write(32'h600, 32'h12345678, 1'b1, 1);
`ifdef SRAM_CACHE_WRITE_UPDATE_EN
    read_hit(32'h600, 32'h12345678);
`else
    read_miss(32'h600, 64'h44444444_33333333, 1, 32'h33333333);
`endif

    // Write miss on an empty cache leaves it unchanged
    do_reset();
    do_write(32'h800, 32'hCAFEF00D, 1'b0, 4);
    read_miss(32'h800, 64'h88888888_77777777, 1, 32'h77777777);
    read_hit(32'h804, 32'h88888888);

    // Reset two cycles into a miss
    read_miss(32'h400, 64'h22222222_11111111, 1, 32'h11111111);
    read_hit(32'h400, 32'h11111111);
    mem_r_en = 1'b1; address = 32'h600;
    settle();
    chk("rstmid_hit", hit, 1'b0);
    cyc();
    cyc();
    chk("rstmid_ren_before", sram_r_en, 1'b1);
    rst = 1'b0;
    settle();
    chk("rstmid_ren", sram_r_en, 1'b0);
    chk("rstmid_ready_req", ready, 1'b0);
    mem_r_en = 1'b0;
    settle();
    chk("rstmid_ready_idle", ready, 1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    read_miss(32'h400, 64'h22222222_11111111, 1, 32'h11111111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
